fb_port_arbiter: RTL and testbench

//  Shares one single-port frame-buffer RAM between the HDMI display read path and the

---
 rtl/fb_pkg.sv | 13 +
 rtl/fb_port_arbiter_if.sv | 41 ++++
 rtl/fb_wbuf_fifo.sv | 53 +++++
 rtl/fb_port_arbiter.sv | 133 +++++++++++++
 tb/tb_fb_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: bus widths, arbiter states and read pipeline depth.
package fb_pkg;

   localparam int FB_ADDR_W  = 19;
   localparam int FB_DATA_W  = 24;
   localparam int RD_LATENCY = 3;

   typedef enum logic {
      RUN,
      FLUSH
   } fb_arb_state_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Client and RAM-side signals of the frame-buffer port arbiter.
// The slave modport is the arbiter; the master modport is the clients plus the RAM.
interface fb_port_arbiter_if
   import fb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int WBUF_DEPTH = 8
);
   localparam int LVL_W = $clog2(WBUF_DEPTH) + 1;

   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              flush_req;
   logic              flush_done;
   logic              starve;
   logic [LVL_W-1:0]  wbuf_level;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  rd_en, rd_addr, wr_valid, wr_addr, wr_data, flush_req, mem_rdata,
      output rd_data, rd_valid, wr_ready, flush_done, starve, wbuf_level,
             mem_addr, mem_we, mem_wdata
   );

   modport master (
      output rd_en, rd_addr, wr_valid, wr_addr, wr_data, flush_req, mem_rdata,
      input  rd_data, rd_valid, wr_ready, flush_done, starve, wbuf_level,
             mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/fb_wbuf_fifo.sv
// Synchronous write-buffer FIFO; push while full is honoured only alongside a pop,
// and a pop while empty is ignored.
module fb_wbuf_fifo #(
   parameter int WIDTH = 43,
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads own the port whenever requested,
// buffered compute writes drain into idle cycles, with flush handshake and starve flag.
module fb_port_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int WBUF_DEPTH = 8,
   parameter int STARVE_LIM = 1024
) (
   input logic              clk,
   input logic              reset_n,
   fb_port_arbiter_if.slave bus
);

   localparam int LVL_W = $clog2(WBUF_DEPTH) + 1;
   localparam int CNT_W = $clog2(STARVE_LIM + 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_entry_t;

   wr_entry_t         push_entry;
   wr_entry_t         head;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [LVL_W-1:0]  level;
   fb_arb_state_t     state;
   fb_arb_state_t     state_next;
   logic              wr_ready;
   logic              flush_done;
   logic [RD_LATENCY-1:0] rd_pipe;
   logic [CNT_W-1:0]  starve_cnt;
   logic              starve_q;

   assign push_entry = '{addr: bus.wr_addr, data: bus.wr_data};
   assign push       = bus.wr_valid && wr_ready;
   assign pop        = !bus.rd_en && !empty;

   fb_wbuf_fifo #(
      .WIDTH ($bits(wr_entry_t)),
      .DEPTH (WBUF_DEPTH)
   ) u_wbuf (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .din     (push_entry),
      .pop     (pop),
      .dout    (head),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= RUN;
      else          state <= state_next;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      wr_ready   = 1'b0;
      flush_done = 1'b0;
      case (state)
         RUN: begin
            wr_ready = !full;
            if (bus.flush_req) state_next = FLUSH;
         end
         FLUSH: begin
            if (empty) begin
               flush_done = 1'b1;
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   // Port slot: reads win outright; a queued write takes any cycle without a read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.mem_addr  <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_wdata <= '0;
      end else if (bus.rd_en) begin
         bus.mem_addr  <= bus.rd_addr;
         bus.mem_we    <= 1'b0;
      end else if (pop) begin
         bus.mem_addr  <= head.addr;
         bus.mem_wdata <= head.data;
         bus.mem_we    <= 1'b1;
      end else begin
         bus.mem_we    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pipe     <= '0;
         bus.rd_data <= '0;
      end else begin
         rd_pipe     <= {rd_pipe[RD_LATENCY-2:0], bus.rd_en};
         bus.rd_data <= bus.mem_rdata;
      end
   end

   // Counts consecutive cycles a pending write lost the port; saturates at the limit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
         starve_q   <= 1'b0;
      end else begin
         if (flush_done) starve_q <= 1'b0;
         if (pop) begin
            starve_cnt <= '0;
         end else if (!empty && bus.rd_en && starve_cnt != CNT_W'(STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
            if (starve_cnt == CNT_W'(STARVE_LIM - 1)) starve_q <= 1'b1;
         end
      end
   end

   assign bus.rd_valid   = rd_pipe[RD_LATENCY-1];
   assign bus.wr_ready   = wr_ready;
   assign bus.flush_done = flush_done;
   assign bus.starve     = starve_q && !flush_done;
   assign bus.wbuf_level = level;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: vector table for read/write slotting plus
// hand-written sequences for backpressure, flush, starve and mid-operation reset.
module tb_fb_port_arbiter;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 24;
   localparam int DEPTH  = 8;

   typedef struct {
      logic              rd_en;
      logic [ADDR_W-1:0] rd_addr;
      logic              wr_valid;
      logic [ADDR_W-1:0] wr_addr;
      logic [DATA_W-1:0] wr_data;
      logic              exp_rd_valid;
      logic [DATA_W-1:0] exp_rd_data;
      logic              exp_we;
      logic [ADDR_W-1:0] exp_addr;
      logic [DATA_W-1:0] exp_wdata;
      logic [3:0]        exp_level;
      logic              exp_wr_ready;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [DATA_W-1:0] ram [1024];
   logic [DATA_W-1:0] ram_q = '0;

   fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(DEPTH)) bus ();

   fb_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .WBUF_DEPTH (DEPTH),
      .STARVE_LIM (16)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Registered-read RAM model with one cycle of latency.
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr[9:0]] <= bus.mem_wdata;
      ram_q <= ram[bus.mem_addr[9:0]];
   end
   assign bus.mem_rdata = ram_q;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rd_en, input logic [ADDR_W-1:0] rd_addr,
                        input logic wr_valid, input logic [ADDR_W-1:0] wr_addr,
                        input logic [DATA_W-1:0] wr_data, input logic flush_req);
      bus.rd_en     = rd_en;
      bus.rd_addr   = rd_addr;
      bus.wr_valid  = wr_valid;
      bus.wr_addr   = wr_addr;
      bus.wr_data   = wr_data;
      bus.flush_req = flush_req;
   endtask

   function automatic logic [DATA_W-1:0] pix(int k);
      return 24'h5A0000 + DATA_W'(k * 17);
   endfunction

   vec_t vecs[$];

   initial begin
      vec_t v;
      int   n_acc;

      for (int i = 0; i < 1024; i++) ram[i] = DATA_W'(i * 3);

      // Reads of 0..3, then idle rows for the 3-cycle pipeline to empty.
      for (int k = 0; k < 7; k++) begin
         v = '{default: '0};
         v.rd_en        = (k < 4);
         v.rd_addr      = ADDR_W'(k < 4 ? k : 0);
         v.exp_rd_valid = (k >= 2 && k <= 5);
         v.exp_rd_data  = DATA_W'((k - 2) * 3);
         v.exp_addr     = ADDR_W'(k < 4 ? k : 3);
         v.exp_wr_ready = 1'b1;
         vecs.push_back(v);
      end
      // Eight writes with no reads: each drains the cycle after it is accepted.
      for (int k = 0; k < 10; k++) begin
         v = '{default: '0};
         v.wr_valid     = (k < 8);
         v.wr_addr      = ADDR_W'(100 + k);
         v.wr_data      = pix(k);
         v.exp_we       = (k >= 1 && k <= 8);
         v.exp_addr     = ADDR_W'(k == 0 ? 3 : (k <= 8 ? 100 + k - 1 : 107));
         v.exp_wdata    = pix(k - 1);
         v.exp_level    = 4'(k < 8 ? 1 : 0);
         v.exp_wr_ready = 1'b1;
         vecs.push_back(v);
      end
      // Read back what was written.
      for (int k = 0; k < 11; k++) begin
         v = '{default: '0};
         v.rd_en        = (k < 8);
         v.rd_addr      = ADDR_W'(100 + (k < 8 ? k : 0));
         v.exp_rd_valid = (k >= 2 && k <= 9);
         v.exp_rd_data  = pix(k - 2);
         v.exp_addr     = ADDR_W'(k < 8 ? 100 + k : 107);
         v.exp_wr_ready = 1'b1;
         vecs.push_back(v);
      end

      drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("reset rd_valid", bus.rd_valid, 0);
      check("reset rd_data", bus.rd_data, 0);
      check("reset mem_we", bus.mem_we, 0);
      check("reset mem_addr", bus.mem_addr, 0);
      check("reset mem_wdata", bus.mem_wdata, 0);
      check("reset level", bus.wbuf_level, 0);
      check("reset flush_done", bus.flush_done, 0);
      check("reset starve", bus.starve, 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("wr_ready after release", bus.wr_ready, 1);

      step();
      foreach (vecs[i]) begin
         drive(vecs[i].rd_en, vecs[i].rd_addr, vecs[i].wr_valid, vecs[i].wr_addr,
               vecs[i].wr_data, 1'b0);
         step();
         check($sformatf("vec%0d rd_valid", i), bus.rd_valid, vecs[i].exp_rd_valid);
         if (vecs[i].exp_rd_valid)
            check($sformatf("vec%0d rd_data", i), bus.rd_data, vecs[i].exp_rd_data);
         check($sformatf("vec%0d mem_we", i), bus.mem_we, vecs[i].exp_we);
         check($sformatf("vec%0d mem_addr", i), bus.mem_addr, vecs[i].exp_addr);
         if (vecs[i].exp_we)
            check($sformatf("vec%0d mem_wdata", i), bus.mem_wdata, vecs[i].exp_wdata);
         check($sformatf("vec%0d level", i), bus.wbuf_level, vecs[i].exp_level);
         check($sformatf("vec%0d wr_ready", i), bus.wr_ready, vecs[i].exp_wr_ready);
      end

      // Buffer fills under continuous reads, then drains in order.
      n_acc = 0;
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, '0, 1'b1, ADDR_W'(200 + i), pix(200 + i), 1'b0);
         if (bus.wr_ready) n_acc++;
         step();
      end
      check("full accepted count", n_acc, 8);
      check("full level", bus.wbuf_level, 8);
      check("full wr_ready", bus.wr_ready, 0);
      check("full mem_we", bus.mem_we, 0);
      drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("drain%0d mem_we", k), bus.mem_we, 1);
         check($sformatf("drain%0d mem_addr", k), bus.mem_addr, 200 + k);
         check($sformatf("drain%0d mem_wdata", k), bus.mem_wdata, pix(200 + k));
         check($sformatf("drain%0d level", k), bus.wbuf_level, 7 - k);
         check($sformatf("drain%0d wr_ready", k), bus.wr_ready, 1);
      end
      step();
      check("drained mem_we", bus.mem_we, 0);
      check("drained starve", bus.starve, 0);

      // Flush with three words pending behind reads.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, '0, 1'b1, ADDR_W'(300 + i), pix(300 + i), 1'b0);
         step();
      end
      check("flush pre level", bus.wbuf_level, 3);
      drive(1'b1, '0, 1'b0, '0, '0, 1'b1);
      step();
      drive(1'b1, '0, 1'b1, ADDR_W'(399), pix(399), 1'b0);
      check("flushing wr_ready", bus.wr_ready, 0);
      check("flushing flush_done", bus.flush_done, 0);
      step();
      check("flushing write refused", bus.wbuf_level, 3);
      check("flushing blocked flush_done", bus.flush_done, 0);
      drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("flush drain%0d mem_addr", k), bus.mem_addr, 300 + k);
         check($sformatf("flush drain%0d mem_we", k), bus.mem_we, 1);
         check($sformatf("flush drain%0d level", k), bus.wbuf_level, 2 - k);
         check($sformatf("flush drain%0d flush_done", k), bus.flush_done, k == 2);
      end
      check("flush done wr_ready", bus.wr_ready, 0);
      step();
      check("after flush flush_done", bus.flush_done, 0);
      check("after flush wr_ready", bus.wr_ready, 1);

      // Flush of an already-empty buffer completes one cycle after the request.
      drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
      step();
      drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
      check("empty flush flush_done", bus.flush_done, 1);
      step();
      check("empty flush pulse end", bus.flush_done, 0);

      // Starvation: one word held off by 16 consecutive reads.
      drive(1'b1, '0, 1'b1, ADDR_W'(500), pix(500), 1'b0);
      step();
      drive(1'b1, '0, 1'b0, '0, '0, 1'b0);
      check("starve pre level", bus.wbuf_level, 1);
      for (int i = 1; i <= 16; i++) begin
         step();
         if (i == 15) check("starve at 15", bus.starve, 0);
         if (i == 16) check("starve at 16", bus.starve, 1);
      end
      repeat (4) step();
      check("starve saturated", bus.starve, 1);
      drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
      step();
      check("starve drain mem_addr", bus.mem_addr, 500);
      check("starve sticky after drain", bus.starve, 1);
      drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
      step();
      drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
      check("starve flush_done", bus.flush_done, 1);
      check("starve cleared on flush_done", bus.starve, 0);
      step();
      check("starve stays cleared", bus.starve, 0);

      // Reset with five words buffered and reads in flight.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, ADDR_W'(i), 1'b1, ADDR_W'(600 + i), pix(600 + i), 1'b0);
         step();
      end
      check("pre-reset level", bus.wbuf_level, 5);
      check("pre-reset rd_valid", bus.rd_valid, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid reset rd_valid", bus.rd_valid, 0);
      check("mid reset rd_data", bus.rd_data, 0);
      check("mid reset mem_we", bus.mem_we, 0);
      check("mid reset mem_addr", bus.mem_addr, 0);
      check("mid reset mem_wdata", bus.mem_wdata, 0);
      check("mid reset level", bus.wbuf_level, 0);
      check("mid reset flush_done", bus.flush_done, 0);
      check("mid reset starve", bus.starve, 0);
      drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("post reset%0d mem_we", k), bus.mem_we, 0);
         check($sformatf("post reset%0d rd_valid", k), bus.rd_valid, 0);
         check($sformatf("post reset%0d level", k), bus.wbuf_level, 0);
         check($sformatf("post reset%0d wr_ready", k), bus.wr_ready, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
